// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit: FSM states,
// RV32I load/store funct3 encodings, byte-enable and lane helpers.
package mau_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, ISSUE2, WAIT, RESP} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables for an access of the given width starting at lane off.
  // Lanes that fall off the top of the word are dropped here; the caller
  // handles the spill into the next word. Illegal funct3 enables nothing.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001;
      F3_H, F3_HU: m = 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m << off;
  endfunction

  // Replicate right-justified store data across the word by access size.
  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Rotate a word left / right by whole byte lanes.
  function automatic logic [31:0] lane_rotl(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      2'd3:    return {d[7:0],  d[31:8]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] lane_rotr(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd1:    return {d[7:0],  d[31:8]};
      2'd2:    return {d[15:0], d[31:16]};
      2'd3:    return {d[23:0], d[31:24]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load data alignment: picks the addressed byte/half out of the SRAM word
// and sign/zero-extends it. With MAU_MISALIGN_SPLIT_EN, lanes below the
// offset come from the following word (hi_i) so a word-crossing access
// is merged before the rotate.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] lo_i,
`ifdef MAU_MISALIGN_SPLIT_EN
  input  logic [31:0] hi_i,
`endif
  output logic [31:0] data_o
);

  logic [31:0] merged;
  logic [31:0] r;

  // Merge the two captures per lane, rotate the addressed byte to lane 0, extend
  always_comb begin
`ifdef MAU_MISALIGN_SPLIT_EN
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = (2'(i) >= off_i) ? lo_i[8*i +: 8] : hi_i[8*i +: 8];
`else
    merged = lo_i;
`endif
    r = lane_rotr(merged, off_i);
    case (funct3_i[1:0])
      2'b00:   data_o = {{24{r[7]  & ~funct3_i[2]}}, r[7:0]};
      2'b01:   data_o = {{16{r[15] & ~funct3_i[2]}}, r[15:0]};
      default: data_o = r;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RISC-V load/store unit driving one port of a 1-cycle-latency SRAM.
// One request in flight; every accepted request gets exactly one response.
// Optional feature macro: MAU_MISALIGN_SPLIT_EN splits word-crossing H/W
// accesses into two SRAM cycles; without it, misaligned H/W is an error.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int          LENGTH    = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [2:0]                    req_funct3,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic [$clog2(LENGTH/4)-1:0]   mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic [3:0]                    mem_we,
  input  logic [31:0]                   mem_rdata
);

  localparam int AW = $clog2(LENGTH/4);

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_we_q;

  // Request decode, evaluated on the raw request fields at acceptance
  logic [3:0]  be;
  logic [2:0]  nbytes;
  logic [32:0] rel, end_b;
  logic        f3_ok, range_ok, req_err;
  logic [AW-1:0] word;
  logic [31:0] wd_lanes;
  logic [31:0] ld_data;

  assign be       = be_gen(req_funct3, req_addr[1:0]);
  assign nbytes   = (req_funct3[1:0] == 2'b00) ? 3'd1 : (req_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign f3_ok    = (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                     (!req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU)));
  // rel[32] set means the address sits below the SRAM window
  assign rel      = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign end_b    = {1'b0, rel[31:0]} + {30'b0, nbytes};
  assign range_ok = !rel[32] && (end_b <= 33'(LENGTH));
  assign word     = rel[AW+1:2];
  assign wd_lanes = lane_rotl(replicate(req_funct3[1:0], req_wdata), req_addr[1:0]);

`ifdef MAU_MISALIGN_SPLIT_EN
  logic        cross, split_q;
  logic [3:0]  be_hi, be_hi_q;
  logic [31:0] lo_q;
  // Crossing is decided by the byte span; a misaligned H inside one word is a single access
  assign cross   = ({1'b0, req_addr[1:0]} + nbytes) > 3'd4;
  assign be_hi   = be_gen(req_funct3, 2'd0) >> (3'd4 - {1'b0, req_addr[1:0]});
  assign req_err = !f3_ok || !range_ok;

  mau_load_align u_align (
    .funct3_i (funct3_q),
    .off_i    (off_q),
    .lo_i     (split_q ? lo_q : mem_rdata),
    .hi_i     (mem_rdata),
    .data_o   (ld_data)
  );
`else
  logic misal;
  assign misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_err = !f3_ok || !range_ok || misal;

  mau_load_align u_align (
    .funct3_i (funct3_q),
    .off_i    (off_q),
    .lo_i     (mem_rdata),
    .data_o   (ld_data)
  );
`endif

  // Control FSM; all SRAM and response outputs are registered here
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= '0;
`ifdef MAU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      be_hi_q     <= '0;
      lo_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          funct3_q <= req_funct3;
          we_q     <= req_we;
          off_q    <= req_addr[1:0];
          if (req_err) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end else begin
            mem_addr_q <= word;
            mem_we_q   <= req_we ? be : 4'b0000;
            if (req_we) mem_wdata_q <= wd_lanes;
`ifdef MAU_MISALIGN_SPLIT_EN
            split_q <= cross;
            be_hi_q <= be_hi;
`endif
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we_q <= 4'b0000;
`ifdef MAU_MISALIGN_SPLIT_EN
          if (split_q) begin
            mem_addr_q <= mem_addr_q + AW'(1);
            mem_we_q   <= we_q ? be_hi_q : 4'b0000;
            state_q    <= ISSUE2;
          end else
`endif
          if (we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
`ifdef MAU_MISALIGN_SPLIT_EN
        ISSUE2: begin
          mem_we_q <= 4'b0000;
          lo_q     <= mem_rdata;
          if (we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
`endif
        WAIT: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ld_data;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1-cycle registered SRAM model
// and an in-order response scoreboard (data, error flag, arrival cycle).
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n, req_valid, req_we, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;
  logic [3:0]  mem_we;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_access_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // SRAM model: byte-lane writes, registered read-before-write
  logic [31:0] mem [0:2047];
  bit init_done;
  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
      mem[5] <= 32'h11223344;
      init_done <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every rsp_valid
  always @(negedge clock) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Wait for ready, present a request, record the expected response (if push).
  // Returns 1 time unit after the accepting edge; req_valid stays high if hold.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input bit push, input bit hold);
    exp_t e;
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    if (push) begin
      e.rdata = er; e.err = ee; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && n < 40) begin
      @(posedge clock); #1; n++;
    end
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clock);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // 1. byte loads, signed and unsigned
    issue(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF99, 1'b0, 3, 1, 0);
    @(negedge clock);
    chk("lb_mem_addr", 32'(mem_addr), 32'd4);
    chk("lb_mem_we", 32'(mem_we), 32'd0);
    chk("lb_busy", {31'b0, req_ready}, 32'd0);
    drain();
    issue(1'b0, 3'b100, 32'h12, 32'h0, 32'h00000099, 1'b0, 3, 1, 0);
    drain();

    // 3. misaligned accesses (before word 5 is modified)
`ifdef MAU_MISALIGN_SPLIT_EN
    issue(1'b0, 3'b010, 32'h13, 32'h0, 32'h22334488, 1'b0, 4, 1, 0);
    @(negedge clock);
    chk("mis_lw_addr_n", 32'(mem_addr), 32'd4);
    chk("mis_lw_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    chk("mis_lw_addr_n1", 32'(mem_addr), 32'd5);
    drain();
    issue(1'b0, 3'b001, 32'h13, 32'h0, 32'h00004488, 1'b0, 4, 1, 0);
    drain();
`else
    issue(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1, 1, 0);
    @(negedge clock);
    chk("mis_lw_we", 32'(mem_we), 32'd0);
    drain();
    issue(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1, 1, 0);
    drain();
`endif

    // 2. halfword store into upper half of word 5, then read back
    issue(1'b1, 3'b001, 32'h16, 32'h0000BEEF, 32'h0, 1'b0, 2, 1, 0);
    @(negedge clock);
    chk("sh_mem_we", 32'(mem_we), 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("sh_mem_addr", 32'(mem_addr), 32'd5);
    @(negedge clock);
    chk("sh_we_one_cycle", 32'(mem_we), 32'd0);
    drain();
    issue(1'b0, 3'b010, 32'h14, 32'h0, 32'hBEEF3344, 1'b0, 3, 1, 0);
    drain();

    // 4. range boundaries and illegal funct3
    issue(1'b1, 3'b010, 32'h1FFC, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 0);
    @(negedge clock);
    chk("sw_last_addr", 32'(mem_addr), 32'd2047);
    chk("sw_last_we", 32'(mem_we), 32'hF);
    drain();
    issue(1'b0, 3'b010, 32'h1FFC, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0);
    drain();
    issue(1'b1, 3'b010, 32'h2000, 32'hDEADBEEF, 32'h0, 1'b1, 1, 1, 0);
    @(negedge clock);
    chk("sw_oob_we", 32'(mem_we), 32'd0);
    drain();
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 3, 1, 0);
    drain();
    issue(1'b0, 3'b010, 32'h1FFC, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0);
    drain();
    issue(1'b0, 3'b001, 32'h1FFF, 32'h0, 32'h0, 1'b1, 1, 1, 0);
    drain();
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1, 0);
    drain();

    // 5. back-to-back with req_valid held high
    issue(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 3, 1, 1);
    @(negedge clock);
    chk("b2b_busy0", {31'b0, req_ready}, 32'd0);
    issue(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1, 1);
    @(negedge clock);
    chk("b2b_busy1", {31'b0, req_ready}, 32'd0);
    issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 3, 1, 1);
    @(negedge clock);
    chk("b2b_busy2", {31'b0, req_ready}, 32'd0);
    issue(1'b1, 3'b000, 32'h40, 32'h0000005A, 32'h0, 1'b0, 2, 1, 1);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0000005A, 1'b0, 3, 1, 0);
    drain();

    // 6. reset during WAIT of a load: no response, then normal service
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, 3, 0, 0);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 3, 1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
